// File: rtl/sr_fetch_pkg.sv
// sr_fetch_pkg: shared types and constants for the fetch stage
package sr_fetch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
   localparam int INSTR_W = 32;
   localparam int ENTRY_W = 2 * INSTR_W;
   localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/sr_fetch_fifo.sv
// sr_fetch_fifo: 2-entry skid buffer whose head is a register, so rd_data holds its last value when empty
module sr_fetch_fifo import sr_fetch_pkg::*; (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [1:0]         count
);
   logic [ENTRY_W-1:0] tail;
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         rd_data <= '0;
         tail <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         rd_data <= pop ? (count == 2'd2 ? tail : push ? wr_data : rd_data)
                        : (push && count == 2'd0 ? wr_data : rd_data);
         tail <= push && (pop ? count == 2'd2 : count == 2'd1) ? wr_data : tail;
      end
   end
endmodule

// File: rtl/sr_fetch_unit.sv
// sr_fetch_unit: PC and fetch FSM driving the instruction ROM, buffering words for decode
module sr_fetch_unit import sr_fetch_pkg::*; #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ROM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_enable,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        fault
);
   localparam logic [31:0] ROM_LIM = ROM_WORDS;
   state_t state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [1:0] count;
   logic pop, push, redir, misaligned, opp, oob;
   assign imem_addr = {2'b00, pc[31:2]};
   assign out_valid = count != 2'd0;
   assign fault = state == FAULT;
   assign pop = out_valid && out_ready;
   assign redir = redirect_valid && state != FAULT;
   assign misaligned = redirect_pc[1:0] != 2'b00;
   // a push opportunity with the PC past the ROM end faults instead of fetching
   assign opp = state == RUN && !redir && (count != 2'd2 || pop);
   assign oob = imem_addr >= ROM_LIM;
   assign push = opp && !oob;
   always_comb begin
      state_nx = state;
      pc_nx = pc;
      if (redir) begin
         state_nx = misaligned ? FAULT : state;
         pc_nx = misaligned ? pc : redirect_pc;
      end else if (opp && oob) begin
         state_nx = FAULT;
      end else begin
         pc_nx = push ? pc + PC_STEP : pc;
         state_nx = state == IDLE && fetch_enable ? RUN
                  : state == RUN && !fetch_enable ? IDLE : state;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
      end
   end
   sr_fetch_fifo u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .flush(redir),
      .wr_data({pc, imem_data}),
      .rd_data({out_pc, out_instr}),
      .count(count)
   );
endmodule

// File: tb/tb_sr_fetch_unit.sv
// tb_sr_fetch_unit: randomized bench with a queue-based reference model and a decoupled scoreboard monitor
module tb_sr_fetch_unit;
   localparam int ROM_WORDS = 64;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1, fetch_enable = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr, imem_data, out_instr, out_pc;
   logic out_valid, fault;
   logic [31:0] rom [ROM_WORDS];
   ent_t exp_q[$];
   ent_t e;
   int checks = 0, failures = 0;
   int m_st = 0;
   logic [31:0] m_pc = '0;
   bit armed = 0, pre_valid = 0, pre_fault = 0, pop_void = 0;
   logic [31:0] pre_addr = '0;

   sr_fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(ROM_WORDS)) dut (
      .clk(clk), .rst(rst), .fetch_enable(fetch_enable), .imem_addr(imem_addr),
      .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .fault(fault));

   always #5 clk = ~clk;
   assign imem_data = imem_addr < ROM_WORDS ? rom[imem_addr[5:0]] : 32'hdead_beef;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one clock of stimulus; the model advances by the architectural rules and queues expected deliveries
   task automatic cyc(bit r, bit fe, bit rv, logic [31:0] rpc, bit rdy);
      bit pop, opp;
      @(posedge clk);
      #2;
      rst = r; fetch_enable = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      pre_valid = exp_q.size() != 0;
      pre_fault = m_st == 2;
      pre_addr = m_pc >> 2;
      pop_void = r || (rv && m_st != 2);
      if (r) begin
         exp_q.delete(); m_pc = 32'h0; m_st = 0;
      end else if (rv && m_st != 2) begin
         exp_q.delete();
         if (rpc[1:0] != 2'b00) m_st = 2; else m_pc = rpc;
      end else begin
         pop = exp_q.size() != 0 && rdy;
         opp = m_st == 1 && (exp_q.size() < 2 || pop);
         if (opp && m_pc[31:2] >= ROM_WORDS) m_st = 2;
         else begin
            if (opp) begin
               exp_q.push_back('{m_pc, rom[m_pc[7:2]]});
               m_pc = m_pc + 32'd4;
            end
            if (m_st == 0 && fe) m_st = 1;
            else if (m_st == 1 && !fe) m_st = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("out_valid", 32'(out_valid), 32'(pre_valid));
         chk("fault", 32'(fault), 32'(pre_fault));
         chk("imem_addr", imem_addr, pre_addr);
         if (pre_valid && out_ready && !pop_void) begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
         end
      end
   end

   initial begin
      for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
      cyc(1, 0, 0, 0, 0);
      armed = 1;
      cyc(1, 0, 0, 0, 0);
      #3;
      chk("reset_out_pc", out_pc, 32'h0);
      chk("reset_out_instr", out_instr, 32'h0);
      // straight-line run at full throughput
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1);
      // backpressure then release
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);
      // redirect flushes two buffered entries
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 32'h40, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
      // misaligned redirect faults; later redirect is ignored
      cyc(0, 1, 1, 32'h42, 1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 1, 32'h0, 1);
      for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      // run off the end of the ROM
      cyc(0, 0, 1, 32'hF0, 1);
      for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      // drop fetch_enable with entries buffered, then resume
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom % 4 == 0) ? {$urandom_range(0, 70), 2'($urandom_range(1, 3))}
                                   : {$urandom_range(0, 70), 2'b00};
         cyc($urandom % 200 == 0, $urandom % 8 != 0, $urandom % 16 == 0, rpc, $urandom % 4 != 0);
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      #4;
      chk("drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sr_fetch_unit.md
Name: sr_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the per-node instruction ROM.
- Holds the program counter and drives the ROM's word address; the ROM read is combinational.
- Captures the returned instruction word with its PC into a 2-entry skid buffer and presents it to decode over a valid/ready handshake.
- Supports branch/jump redirect, a per-node fetch enable for multicore start-up, and a fault stop.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
ROM_WORDS, 64, instruction ROM depth in 32-bit words; word indices >= ROM_WORDS are out of range

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
fetch_enable  input  1  node start; fetch only while high
imem_addr  output  32  ROM word index = pc[31:2] (upper 2 bits zero), combinational from PC
imem_data  input  32  instruction word returned combinationally by ROM for imem_addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  byte target address for redirect
out_valid  output  1  head entry of skid buffer valid
out_instr  output  32  instruction of head entry
out_pc  output  32  byte PC of head entry
out_ready  input  1  decode accepts head entry this cycle
fault  output  1  sticky fault flag (misaligned redirect or PC out of ROM range)

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, buffer count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, so imem_addr=RESET_PC>>2. Reset overrides all other inputs, including mid-run.
- States:
  - IDLE: no fetch. Goes to RUN at the edge where fetch_enable=1.
  - RUN: fetching. Goes back to IDLE when fetch_enable=0; PC and buffer contents are kept, and the buffer still drains to decode.
  - FAULT: absorbing until rst. fault=1 in FAULT.
- Pop: occurs when out_valid && out_ready.
- Push condition: in RUN, with no redirect, and either count<2 or a pop in the same cycle.
- Push action: write {pc, imem_data} to buffer tail and set pc<=pc+4 (wraps modulo 2^32).
- Latency: the first instruction shows out_valid=1 the cycle after the first RUN cycle. Sustained throughput is 1 instr/cycle with out_ready=1.
- Backpressure: with out_ready=0, the buffer fills to 2 and the PC holds. No word is lost or duplicated, and PC order is preserved.
- Range check: if in RUN and pc[31:2] >= ROM_WORDS at a push opportunity, go to FAULT with no push and PC held. Entries already buffered stay valid and drain normally.
- Redirect (redirect_valid=1) has highest priority after reset, in any state except FAULT:
  - Buffer is flushed (count<=0); any same-cycle pop is void and any same-cycle fetched word is discarded.
  - pc<=redirect_pc.
  - State is unchanged (IDLE stays IDLE, RUN stays RUN).
- Misaligned redirect (redirect_pc[1:0]!=0): flush, pc unchanged, go to FAULT.
- In FAULT, redirect is ignored and pushes are suppressed.
- out_instr/out_pc are registered buffer outputs. When count=0 they hold their last value, but only out_valid is meaningful.
- Simultaneous push and pop at count=2: both happen, and count stays 2.

Decomposition:
- Package sr_fetch_pkg: state encoding (IDLE=2'd0, RUN=2'd1, FAULT=2'd2), INSTR_W=32, PC_STEP=4.
- Sub-module sr_fetch_fifo: 2-entry, 64-bit-wide synchronous FIFO.
  - Ports: push, pop, flush, data in/out, count.
  - Flush has priority over push/pop.
  - Instantiated once in the top.
- All FSM, PC and range logic stays in sr_fetch_unit.

Test Plan:
1. Reset, fetch_enable=1, out_ready=1, ROM holding distinct words -> out_pc sequence 0x0,0x4,0x8,… with matching out_instr; first out_valid exactly 1 cycle after entering RUN.
2. Run, then hold out_ready=0 for 5 cycles -> count saturates at 2 holding PCs 0x0,0x4; imem_addr holds 2. On release, decode sees 0x0,0x4,0x8 with no gaps or duplicates.
3. Two entries buffered, pulse redirect_valid with redirect_pc=0x40 and out_ready=1 -> buffered entries are never accepted; the next accepted entry has out_pc=0x40, then 0x44.
4. redirect_pc=0x42 -> fault=1 next cycle, out_valid=0, no further fetches. A later redirect to 0x0 is ignored; rst clears fault and pc=RESET_PC.
5. ROM_WORDS=4, straight-line run -> PCs 0x0–0xC are delivered, then fault=1 with pc held at 0x10 and imem_addr=4.
6. Drop fetch_enable mid-run with entries buffered -> buffer drains, no new pushes, PC held. Re-assert fetch_enable -> fetch resumes at the held PC.
